// File: rtl/score_keeper.sv
// Game-control stage: debounced start/hit buttons, timed round,
// and a saturating two-digit BCD hit score for the 7-segment decoder.

module score_keeper_db #(
   parameter int unsigned CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int unsigned W = $clog2(CYC > 1 ? CYC : 2);
   localparam logic [W-1:0] MAX = W'(CYC - 1);

   logic [1:0]   sync_q;
   logic         db_q, db_d;
   logic         db_prev_q;
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync_q[1] != db_q) begin
         if (cnt_q == MAX) begin
            db_d  = sync_q[1];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync_q    <= {sync_q[0], btn_i};
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
      end
   end

   assign pulse_o = db_q & ~db_prev_q;

endmodule

module score_keeper #(
   parameter int unsigned DEBOUNCE_CYC = 240000,
   parameter int unsigned TICK_DIV     = 12000000,
   parameter int unsigned GAME_SEC     = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_hit,
   output logic [3:0] seg_data_1,
   output logic [3:0] seg_data_2,
   output logic       playing,
   output logic       game_over
);

   localparam int unsigned TW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [7:0]    sec_q, sec_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          start_p, hit_p, tick;

   score_keeper_db #(.CYC(DEBOUNCE_CYC)) u_db_start (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_start),
      .pulse_o (start_p)
   );

   score_keeper_db #(.CYC(DEBOUNCE_CYC)) u_db_hit (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_hit),
      .pulse_o (hit_p)
   );

   assign tick = (state_q == PLAY) && (tick_q == TICK_MAX);

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      sec_d   = sec_q;
      tick_d  = '0;
      unique case (state_q)
         IDLE, OVER: begin
            // start wins over a coincident hit; score restarts at 00
            if (start_p) begin
               state_d = PLAY;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               sec_d   = 8'(GAME_SEC);
            end
         end
         PLAY: begin
            if (hit_p) begin
               if (ones_q != 4'd9) begin
                  ones_d = ones_q + 4'd1;
               end else if (tens_q != 4'd9) begin
                  ones_d = 4'd0;
                  tens_d = tens_q + 4'd1;
               end
            end
            if (tick) begin
               if (sec_q == 8'd1) begin
                  state_d = OVER;
               end else begin
                  sec_d = sec_q - 8'd1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         sec_q   <= 8'd0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         sec_q   <= sec_d;
         tick_q  <= tick_d;
      end
   end

   assign seg_data_1 = tens_q;
   assign seg_data_2 = ones_q;
   assign playing    = (state_q == PLAY);
   assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a short-round instance and a
// long-round instance for carry, saturation and mid-round reset.

module tb_score_keeper;

   logic       clk = 1'b0;
   logic       rst_m, start_m, hit_m;
   logic       rst_s, start_s, hit_s;
   logic [3:0] t_m, o_m, t_s, o_s;
   logic       play_m, over_m, play_s, over_s;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int sat_cnt = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   score_keeper #(.DEBOUNCE_CYC(4), .TICK_DIV(10), .GAME_SEC(3)) u_m (
      .clk        (clk),
      .rst        (rst_m),
      .btn_start  (start_m),
      .btn_hit    (hit_m),
      .seg_data_1 (t_m),
      .seg_data_2 (o_m),
      .playing    (play_m),
      .game_over  (over_m)
   );

   score_keeper #(.DEBOUNCE_CYC(4), .TICK_DIV(10), .GAME_SEC(255)) u_s (
      .clk        (clk),
      .rst        (rst_s),
      .btn_start  (start_s),
      .btn_hit    (hit_s),
      .seg_data_1 (t_s),
      .seg_data_2 (o_s),
      .playing    (play_s),
      .game_over  (over_s)
   );

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         total++;
         fails++;
         $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic hit_sat(input string tag);
      sat_cnt = (sat_cnt < 99) ? sat_cnt + 1 : 99;
      exp_q.push_back(bcd(sat_cnt));
      hit_s = 1'b1;
      cyc(7);
      sb_pop(tag, {t_s, o_s});
      hit_s = 1'b0;
      cyc(6);
   endtask

   initial begin
      logic seen;
      rst_m = 1'b1; start_m = 1'b0; hit_m = 1'b0;
      rst_s = 1'b1; start_s = 1'b0; hit_s = 1'b0;
      cyc(3);
      rst_m = 1'b0;
      rst_s = 1'b0;
      chk("rst_digits", {t_m, o_m}, 8'h00);
      chk("rst_playing", 8'(play_m), 8'd0);
      chk("rst_over", 8'(over_m), 8'd0);
      chk("rst_s_digits", {t_s, o_s}, 8'h00);

      hit_m = 1'b1;
      cyc(20);
      chk("idle_hit_digits", {t_m, o_m}, 8'h00);
      chk("idle_hit_playing", 8'(play_m), 8'd0);
      hit_m = 1'b0;
      cyc(8);

      seen = 1'b0;
      repeat (10) begin
         start_m = ~start_m;
         repeat (2) begin
            cyc(1);
            seen = seen | play_m;
         end
      end
      start_m = 1'b0;
      repeat (8) begin
         cyc(1);
         seen = seen | play_m;
      end
      chk("glitch_no_play", 8'(seen), 8'd0);

      start_m = 1'b1;
      cyc(6);
      chk("start_lat_early", 8'(play_m), 8'd0);
      cyc(1);
      chk("start_lat_exact", 8'(play_m), 8'd1);
      chk("start_digits", {t_m, o_m}, 8'h00);
      cyc(1);
      hit_m = 1'b1;
      exp_q.push_back(bcd(1));
      cyc(2);
      start_m = 1'b0;
      cyc(5);
      sb_pop("hit1", {t_m, o_m});
      hit_m = 1'b0;
      cyc(15);
      hit_m = 1'b1;
      exp_q.push_back(bcd(2));
      cyc(6);
      chk("pre_expiry_play", 8'(play_m), 8'd1);
      chk("pre_expiry_over", 8'(over_m), 8'd0);
      chk("pre_expiry_digits", {t_m, o_m}, 8'h01);
      cyc(1);
      chk("expiry_play", 8'(play_m), 8'd0);
      chk("expiry_over", 8'(over_m), 8'd1);
      sb_pop("final_tick_hit", {t_m, o_m});
      hit_m = 1'b0;
      cyc(7);

      exp_q.push_back(bcd(2));
      hit_m = 1'b1;
      cyc(7);
      sb_pop("over_hit_frozen", {t_m, o_m});
      chk("over_hold", 8'(over_m), 8'd1);
      hit_m = 1'b0;
      cyc(7);

      exp_q.push_back(bcd(0));
      start_m = 1'b1;
      hit_m   = 1'b1;
      cyc(7);
      sb_pop("restart_simul", {t_m, o_m});
      chk("restart_play", 8'(play_m), 8'd1);
      chk("restart_over", 8'(over_m), 8'd0);
      start_m = 1'b0;
      hit_m   = 1'b0;
      cyc(7);

      start_s = 1'b1;
      cyc(7);
      chk("s_start", 8'(play_s), 8'd1);
      start_s = 1'b0;
      cyc(6);
      for (int i = 1; i <= 5; i++) hit_sat($sformatf("s_hit%0d", i));
      chk("s_five", {t_s, o_s}, 8'h05);
      rst_s = 1'b1;
      cyc(1);
      rst_s = 1'b0;
      chk("midrst_digits", {t_s, o_s}, 8'h00);
      chk("midrst_play", 8'(play_s), 8'd0);
      chk("midrst_over", 8'(over_s), 8'd0);

      start_s = 1'b1;
      cyc(7);
      chk("s_restart", 8'(play_s), 8'd1);
      start_s = 1'b0;
      cyc(6);
      sat_cnt = 0;
      for (int i = 1; i <= 101; i++) begin
         hit_sat($sformatf("sat_hit%0d", i));
         if (i == 9) chk("carry_09", {t_s, o_s}, 8'h09);
         if (i == 10) chk("carry_10", {t_s, o_s}, 8'h10);
      end
      cyc(20);
      chk("sat_hold", {t_s, o_s}, 8'h99);
      chk("sat_playing", 8'(play_s), 8'd1);
      chk("sb_drained", 8'(exp_q.size()), 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
